// File: rtl/rom_streamer_pkg.sv
// Shared constants for rom_streamer: default ROM geometry and the
// sequencer state encoding.
package rom_streamer_pkg;

    localparam int AW_DEFAULT = 9;
    localparam int DW_DEFAULT = 12;

    // Sequencer state encoding. S_CHK is only reachable when the design is
    // built with ROM_STREAMER_CHKSUM_EN.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;

endpackage

// File: rtl/rom_streamer.sv
// rom_streamer: reads a contiguous range of addresses from an external ROM
// with one cycle of registered read latency. The range wraps modulo 2^AW.
// The words are presented on a valid/ready output port, one word every
// three cycles when the consumer never stalls.
// Optional feature macro: ROM_STREAMER_CHKSUM_EN appends a checksum word.
// The checksum is the sum modulo 2^DW of all data words. It carries
// last=1, and the data words then carry last=0.
module rom_streamer
    import rom_streamer_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW-1:0] addr_first,
    input  logic [AW-1:0] addr_last,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] data_out,
    output logic          valid,
    input  logic          ready,
    output logic          last,
    output logic          busy,
    output logic          done
);

    // Handshake: a word moves on a rising edge where valid && ready. Once
    // valid is high, data_out and last stay frozen until that edge, however
    // long ready stays low.
    logic [2:0]    state;
    logic [AW-1:0] last_addr;
    logic          xfer;
    logic          at_end;
`ifdef ROM_STREAMER_CHKSUM_EN
    logic [DW-1:0] checksum;
`endif

    assign xfer   = valid && ready;
    assign at_end = (rom_addr == last_addr);

    // Sequencer. Each word takes three states: ADDR (the ROM samples
    // rom_addr), LOAD (capture rom_data), and SEND (wait for the handshake).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            last_addr <= '0;
            rom_addr  <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef ROM_STREAMER_CHKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        last_addr <= addr_last;
                        rom_addr  <= addr_first;
                        busy      <= 1'b1;
                        state     <= S_ADDR;
`ifdef ROM_STREAMER_CHKSUM_EN
                        checksum  <= '0;
`endif
                    end
                end
                S_ADDR: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    data_out <= rom_data;
                    valid    <= 1'b1;
`ifdef ROM_STREAMER_CHKSUM_EN
                    last     <= 1'b0;
`else
                    last     <= at_end;
`endif
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (xfer) begin
                        valid <= 1'b0;
                        last  <= 1'b0;
`ifdef ROM_STREAMER_CHKSUM_EN
                        checksum <= checksum + data_out;
`endif
                        if (at_end) begin
`ifdef ROM_STREAMER_CHKSUM_EN
                            // The checksum word follows directly, with no ROM access.
                            data_out <= checksum + data_out;
                            valid    <= 1'b1;
                            last     <= 1'b1;
                            state    <= S_CHK;
`else
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_IDLE;
`endif
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= S_ADDR;
                        end
                    end
                end
                S_CHK: begin
                    if (xfer) begin
                        valid <= 1'b0;
                        last  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_streamer.sv
// Testbench for rom_streamer. A behavioural ROM holds ROM[i] = i*3 mod 4096.
// A stream-level model predicts every word and every cycle of busy, valid
// and done. Directed scenarios pin the model with literal values, and a
// randomized phase follows them.
`timescale 1ns/1ps
module tb_rom_streamer;

    localparam int AW = 9;
    localparam int DW = 12;
    localparam int N  = 512;

    typedef struct {
        logic [DW-1:0] d;
        bit            l;
        bit            s;
    } exp_t;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start = 1'b0;
    logic          ready = 1'b0;
    logic [AW-1:0] addr_first = '0;
    logic [AW-1:0] addr_last = '0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] data_out;
    logic          valid;
    logic          last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    rom_streamer #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .addr_first(addr_first), .addr_last(addr_last),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .data_out(data_out), .valid(valid), .ready(ready),
        .last(last), .busy(busy), .done(done)
    );

    // Behavioural ROM with one registered cycle of read latency.
    logic [DW-1:0] rom [N];
    initial for (int i = 0; i < N; i++) rom[i] = DW'((i * 3) % 4096);
    always @(posedge clk) rom_data <= rom[rom_addr];

    // ---------------- scoreboard state ----------------
    int            tests = 0;
    int            fails = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] got_q[$];
    bit            got_l[$];
    logic [DW-1:0] want_d[$];
    bit            want_l[$];
    bit            m_busy = 0;
    bit            m_done = 0;
    int            gap = 0;
    bit            held = 0;
    logic [DW-1:0] held_d = '0;
    bit            ready_auto = 0;
    int            ready_pct = 100;
    bit            b0;
    bit            ev;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Expected words of a stream, derived directly from the address range
    // and the ROM contents.
    function automatic void build(input logic [AW-1:0] f, input logic [AW-1:0] l);
        int   cnt;
        int   a;
        int   sum;
        exp_t e;
        cnt = ((int'(l) - int'(f) + N) % N) + 1;
        sum = 0;
        for (int i = 0; i < cnt; i++) begin
            a   = (int'(f) + i) % N;
            sum = (sum + a * 3) % 4096;
            e.d = DW'((a * 3) % 4096);
            e.s = 0;
`ifdef ROM_STREAMER_CHKSUM_EN
            e.l = 0;
`else
            e.l = (i == cnt - 1);
`endif
            exp_q.push_back(e);
        end
`ifdef ROM_STREAMER_CHKSUM_EN
        e.d = DW'(sum);
        e.l = 1;
        e.s = 1;
        exp_q.push_back(e);
`endif
    endfunction

    // Per-cycle compare against the model, sampled mid-cycle. The model then
    // advances by one edge. Valid is expected 3 edges after acceptance or
    // after a data transfer, and 1 edge before a checksum word.
    always @(negedge clk) begin
        if (rstn) begin
            if (gap > 0) gap--;
            ev = m_busy && (gap == 0) && (exp_q.size() > 0);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("valid", valid, ev);
            if (valid && ev) begin
                chk("data", data_out, exp_q[0].d);
                chk("last", last, exp_q[0].l);
            end
            if (held) chk("stall_hold", data_out, held_d);
            held   = valid && !ready;
            held_d = data_out;
            b0     = m_busy;
            m_done = 0;
            if (valid && ev && ready) begin
                void'(exp_q.pop_front());
                got_q.push_back(data_out);
                got_l.push_back(last);
                if (exp_q.size() == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    gap = exp_q[0].s ? 1 : 3;
                end
            end
            if (!b0 && start) begin
                build(addr_first, addr_last);
                m_busy = 1;
                gap    = 3;
            end
        end
    end

    // Random ready pattern when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (ready_auto) ready = ($urandom_range(1, 100) <= ready_pct);
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
        @(posedge clk);
        #1;
        start      = 1'b1;
        addr_first = f;
        addr_last  = l;
        @(posedge clk);
        #1;
        start      = 1'b0;
        addr_first = AW'($urandom);
        addr_last  = AW'($urandom);
    endtask

    // Waits for the done pulse within a cycle budget. With glitch set, it
    // pokes start and the address inputs while the stream is between words.
    task automatic wait_done(input int budget, input bit glitch, output int n);
        bit ok;
        ok = 0;
        n  = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (glitch) begin
                start      = busy && !valid && ($urandom_range(0, 2) == 0);
                addr_first = AW'($urandom);
                addr_last  = AW'($urandom);
            end
            @(negedge clk);
            n++;
            if (done) begin
                ok = 1;
                break;
            end
        end
        if (glitch) start = 1'b0;
        chk("done_timeout", ok, 1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (valid) break;
        end
        chk("valid_timeout", valid, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        exp_q.delete();
        m_busy = 0;
        m_done = 0;
        gap    = 0;
        held   = 0;
        start  = 1'b0;
        @(negedge clk);
        #2;
        rstn = 1'b1;
    endtask

    task automatic clear_log();
        got_q.delete();
        got_l.delete();
        want_d.delete();
        want_l.delete();
    endtask

    task automatic want(input int d, input bit l);
        want_d.push_back(DW'(d));
        want_l.push_back(l);
    endtask

    task automatic check_log(input string name);
        chk({name, "_count"}, got_q.size(), want_d.size());
        for (int i = 0; i < got_q.size() && i < want_d.size(); i++) begin
            chk({name, "_word"}, got_q[i], want_d[i]);
            chk({name, "_last"}, got_l[i], want_l[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int n;
        logic [AW-1:0] f;
        logic [AW-1:0] l;

        ready = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk("init_rom_addr", rom_addr, 0);
        chk("init_valid", valid, 0);
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        chk("init_data_out", data_out, 0);
        @(negedge clk);
        #2 rstn = 1'b1;

        // Basic stream 4..7: latency, words, last flag, done length.
        clear_log();
        do_start(4, 7);
        wait_valid(n);
        chk("first_valid_latency", n, 3);
        wait_done(100, 0, n);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        want(12, 0); want(15, 0); want(18, 0);
`ifdef ROM_STREAMER_CHKSUM_EN
        want(21, 0); want(66, 1);
`else
        want(21, 1);
`endif
        check_log("basic");

        // Wrapping range 510..1 with ready high throughout.
        clear_log();
        do_start(510, 1);
        wait_done(100, 0, n);
`ifdef ROM_STREAMER_CHKSUM_EN
        chk("wrap_cycles", n, 13);
        want(1530, 0); want(1533, 0); want(0, 0); want(3, 0); want(3066 % 4096, 1);
`else
        chk("wrap_cycles", n, 12);
        want(1530, 0); want(1533, 0); want(0, 0); want(3, 1);
`endif
        check_log("wrap");

        // Single word with a 10-cycle stall.
        clear_log();
        ready = 1'b0;
        do_start(100, 100);
        wait_valid(n);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_data", data_out, 300);
            chk("stall_valid", valid, 1);
        end
        @(posedge clk);
        #1 ready = 1'b1;
        wait_done(100, 0, n);
`ifdef ROM_STREAMER_CHKSUM_EN
        want(300, 0); want(300, 1);
`else
        want(300, 1);
`endif
        check_log("single");

        // Reset during SEND of word 2 of 4, then a normal stream.
        clear_log();
        ready = 1'b0;
        do_start(4, 7);
        wait_valid(n);
        @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        wait_valid(n);
        chk("abort_words_before", got_q.size(), 1);
        do_reset();
        ready = 1'b1;
        repeat (5) @(negedge clk);
        clear_log();
        do_start(4, 7);
        wait_done(100, 0, n);
        want(12, 0); want(15, 0); want(18, 0);
`ifdef ROM_STREAMER_CHKSUM_EN
        want(21, 0); want(66, 1);
`else
        want(21, 1);
`endif
        check_log("after_abort");

        // start held high: ignored while busy, accepted again at done.
        clear_log();
        @(posedge clk);
        #1;
        start      = 1'b1;
        addr_first = 20;
        addr_last  = 22;
        @(posedge clk);
        #1;
        addr_first = 30;
        addr_last  = 31;
        wait_done(100, 0, n);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(100, 0, n);
`ifdef ROM_STREAMER_CHKSUM_EN
        want(60, 0); want(63, 0); want(66, 0); want(189, 1);
        want(90, 0); want(93, 0); want(183, 1);
`else
        want(60, 0); want(63, 0); want(66, 1);
        want(90, 0); want(93, 1);
`endif
        check_log("held_start");

        // Randomized streams with random back-pressure and input noise.
        ready_auto = 1;
        for (int it = 0; it < 40; it++) begin
            ready_pct = $urandom_range(30, 100);
            f = AW'($urandom_range(0, N - 1));
            if ($urandom_range(0, 7) == 0) l = f;
            else l = AW'((int'(f) + $urandom_range(0, 10)) % N);
            do_start(f, l);
            if (it == 20) begin
                repeat ($urandom_range(2, 8)) @(posedge clk);
                do_reset();
            end else begin
                wait_done(400, 1, n);
                chk("stream_drained", exp_q.size(), 0);
            end
        end
        ready_auto = 0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
